hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Parametrised stall/flush controller for the RV32I pipeline; successor to the single-cycle load-use/jump hazard logic.
- Sits beside the IF/ID and ID/EX pipeline registers and drives PC, pipeline-register enables, bubbles and flushes.
- Adds a configurable load-use latency (multi-cycle stalls tracked by an FSM) and data-memory wait freezes.
- Adds instruction-fetch wait bubbles, per-source register-use qualification, and saturating performance counters.

Parameters:
- REG_AW, 5, register-address width
- LOAD_LAT, 1, bubbles needed between a load in EX and a dependent instruction in ID (legal 1..4)
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- idex_mem_read  in  1  instruction in EX is a load
- idex_rd  in  REG_AW  destination register of the instruction in EX
- ifid_rs1  in  REG_AW  source 1 of the instruction in ID
- ifid_rs2  in  REG_AW  source 2 of the instruction in ID
- ifid_use_rs1  in  1  ID instruction actually reads rs1
- ifid_use_rs2  in  1  ID instruction actually reads rs2
- redirect  in  1  taken branch/jump resolved in EX; held by upstream while EX is frozen
- dmem_busy  in  1  data memory not ready; MEM stage cannot complete
- imem_busy  in  1  instruction memory not ready; no valid fetch this cycle
- cnt_clear  in  1  synchronous clear of both counters
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  load NOP into ID/EX (control zeroed)
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- stall_count  out  CNT_W  cycles with pc_write=0
- flush_count  out  CNT_W  redirect events accepted

Behaviour:
- Reset (asynchronous): FSM=RUN, rem=0, held_rd=0, both counters=0.
- Outputs during reset: pc_write=1, ifid_write=1; all other control outputs 0.
- Load-use hit (combinational): hit = idex_mem_read & idex_rd≠0 & ((ifid_use_rs1 & rs1==idex_rd) | (ifid_use_rs2 & rs2==idex_rd)).
- States:
  - RUN: normal operation.
  - LSTALL: additional load-stall cycles; rem counts the remaining cycles, width clog2(LOAD_LAT) (minimum 1).
- Priority, evaluated every cycle; the first matching rule applies:
  1. dmem_busy: pipe_freeze=1, pc_write=0, ifid_write=0, no bubble, no flush. FSM, rem and held state are unchanged.
  2. redirect: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. FSM goes to RUN (any load stall is abandoned because the dependent instruction is wrong-path). flush_count increments.
  3. hit in RUN: pc_write=0, ifid_write=0, idex_bubble=1.
     - If LOAD_LAT>1: go to LSTALL with rem=LOAD_LAT-1.
     - If LOAD_LAT=1: stay in RUN.
  4. In LSTALL: same outputs as rule 3. Decrement rem; when rem reaches 1 in this cycle, return to RUN.
     - Total bubbles per load-use hazard = LOAD_LAT exactly.
  5. imem_busy: pc_write=0, ifid_write=1, ifid_flush=1 (a NOP enters ID); downstream stages proceed.
  6. Otherwise: pc_write=1, ifid_write=1, all other outputs 0.
- A hit while in LSTALL is not re-armed. The ID instruction is unchanged and its producer has left EX.
- x0 as a destination never stalls. Sources whose use flag is 0 never stall.
- stall_count increments on every cycle with pc_write=0, dmem freezes included.
- Both counters saturate at 2^CNT_W-1; they never wrap.
- cnt_clear has priority over increment: the counter is 0 on the next cycle.
- All outputs except the counters are combinational from the inputs and the FSM state. Zero-cycle response.

Decomposition:
- Shared package hazard_pkg holds:
  - REG_AW
  - the state encoding (RUN, LSTALL)
  - the counter-width default
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated twice.

Test Plan:
- LOAD_LAT=1: lw x5 in EX, add using rs1=x5 in ID -> exactly 1 cycle with pc_write=0, idex_bubble=1; stall_count=1.
- LOAD_LAT=3: same hazard -> 3 consecutive bubble cycles, then pc_write=1; FSM back in RUN; stall_count=3.
- LOAD_LAT=3: redirect asserted in the 2nd stall cycle -> ifid_flush=1, idex_bubble=1, pc_write=1 that cycle; no 3rd bubble; flush_count=1.
- dmem_busy for 2 cycles in the middle of a LOAD_LAT=2 stall -> pipe_freeze=1 for 2 cycles; still exactly 2 bubbles total; stall_count=4.
- idex_rd=0 with a load, or rs2 match with ifid_use_rs2=0 -> no stall.
- imem_busy alone -> pc_write=0, ifid_flush=1.
- Counter saturation with CNT_W=2: 5 stall cycles -> stall_count=3.
- Counter clear: cnt_clear asserted together with an increment -> stall_count=0 on the next cycle.
- Reset asserted mid-LSTALL -> outputs return immediately to pc_write=1, ifid_write=1, all others 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_pkg;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } hz_state_e;
endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (inc && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the RV32I pipeline: load-use stalls of LOAD_LAT
// bubbles, data-memory freezes, fetch-wait bubbles, redirect flushes.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_use_rs1,
  input  logic              ifid_use_rs2,
  input  logic              redirect,
  input  logic              dmem_busy,
  input  logic              imem_busy,
  input  logic              cnt_clear,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);
  localparam int REM_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_LAT - 1);

  hz_state_e        state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             hit;

  assign hit = idex_mem_read && (idex_rd != '0) &&
               ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (reset) begin
      // outputs held at the free-running pattern while in reset
    end else if (dmem_busy) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (redirect) begin
      // a pending load stall belongs to a wrong-path instruction
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      rem_d       = '0;
    end else if (hit && (state_q == RUN)) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d = LSTALL;
        rem_d   = REM_INIT;
      end
    end else if (state_q == LSTALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      rem_d       = rem_q - 1'b1;
      if (rem_q <= REM_W'(1)) state_d = RUN;
    end else if (imem_busy) begin
      pc_write   = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_write),
    .clr   (cnt_clear),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect && !dmem_busy),
    .clr   (cnt_clear),
    .count (flush_count)
  );
endmodule

// File: tb/tb_hazard_control_unit.sv
// Four controllers (LOAD_LAT 1..4, last one with 2-bit counters) share one
// stimulus stream and are checked against a bubble-counting reference model.
module tb_hazard_control_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       idex_mem_read = 1'b0;
  logic [4:0] idex_rd = '0, ifid_rs1 = '0, ifid_rs2 = '0;
  logic       ifid_use_rs1 = 1'b0, ifid_use_rs2 = 1'b0;
  logic       redirect = 1'b0, dmem_busy = 1'b0, imem_busy = 1'b0, cnt_clear = 1'b0;

  // ctl bits: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
  logic [4:0]  ctl [4];
  logic [15:0] sc [4];
  logic [15:0] fc [4];
  logic [1:0]  sc3_w, fc3_w;

  int vectors = 0;
  int miscompares = 0;

  int lat  [4] = '{1, 2, 3, 4};
  int cmax [4] = '{65535, 65535, 65535, 3};
  int pend [4];
  int scnt [4];
  int fcnt [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_control_unit #(.REG_AW(5), .LOAD_LAT(g + 1), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
      .ifid_use_rs2(ifid_use_rs2), .redirect(redirect), .dmem_busy(dmem_busy),
      .imem_busy(imem_busy), .cnt_clear(cnt_clear),
      .pc_write(ctl[g][4]), .ifid_write(ctl[g][3]), .ifid_flush(ctl[g][2]),
      .idex_bubble(ctl[g][1]), .pipe_freeze(ctl[g][0]),
      .stall_count(sc[g]), .flush_count(fc[g]));
  end

  hazard_control_unit #(.REG_AW(5), .LOAD_LAT(4), .CNT_W(2)) u_dut4 (
    .clk(clk), .reset(reset), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
    .ifid_use_rs2(ifid_use_rs2), .redirect(redirect), .dmem_busy(dmem_busy),
    .imem_busy(imem_busy), .cnt_clear(cnt_clear),
    .pc_write(ctl[3][4]), .ifid_write(ctl[3][3]), .ifid_flush(ctl[3][2]),
    .idex_bubble(ctl[3][1]), .pipe_freeze(ctl[3][0]),
    .stall_count(sc3_w), .flush_count(fc3_w));

  assign sc[3] = {14'b0, sc3_w};
  assign fc[3] = {14'b0, fc3_w};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check combinational outputs and counters, clock, advance model.
  task automatic step();
    logic [4:0] e;
    bit h;
    #2;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin pend[i] = 0; scnt[i] = 0; fcnt[i] = 0; end
    end
    h = idex_mem_read && (idex_rd != 0) &&
        ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
    for (int i = 0; i < 4; i++) begin
      if (reset)                  e = 5'b11000;
      else if (dmem_busy)         e = 5'b00001;
      else if (redirect)          e = 5'b11110;
      else if (pend[i] > 0 || h)  e = 5'b00010;
      else if (imem_busy)         e = 5'b01100;
      else                        e = 5'b11000;
      chk($sformatf("ctl[lat%0d]", lat[i]), {11'b0, ctl[i]}, {11'b0, e});
      chk($sformatf("stall_count[lat%0d]", lat[i]), sc[i], 16'(scnt[i]));
      chk($sformatf("flush_count[lat%0d]", lat[i]), fc[i], 16'(fcnt[i]));
      if (!reset) begin
        if (cnt_clear) scnt[i] = 0;
        else if (!e[4] && scnt[i] < cmax[i]) scnt[i]++;
        if (cnt_clear) fcnt[i] = 0;
        else if (redirect && !dmem_busy && fcnt[i] < cmax[i]) fcnt[i]++;
        if (dmem_busy)       pend[i] = pend[i];
        else if (redirect)   pend[i] = 0;
        else if (pend[i] > 0) pend[i]--;
        else if (h)          pend[i] = lat[i] - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    ifid_use_rs1 = 0; ifid_use_rs2 = 0; redirect = 0; dmem_busy = 0;
    imem_busy = 0; cnt_clear = 0;
  endtask

  // lw x5 in EX, dependent add (rs1=x5) in ID; EX gets a bubble next cycle
  task automatic load_use();
    idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5; ifid_use_rs1 = 1;
    step();
    idex_mem_read = 0; idex_rd = 0;
  endtask

  task automatic clear_counters();
    idle(); cnt_clear = 1; step(); cnt_clear = 0;
  endtask

  initial begin
    idle();
    reset = 1; step(); step();
    reset = 0;
    step();

    // plain load-use hazard, all latencies
    load_use();
    repeat (5) step();
    chk("lat1_stalls", sc[0], 16'd1);
    chk("lat3_stalls", sc[2], 16'd3);
    chk("lat4_sat",    sc[3], 16'd3);
    clear_counters();
    step();

    // redirect during the 2nd stall cycle
    load_use();
    redirect = 1; step(); redirect = 0;
    repeat (4) step();
    chk("lat3_redirect_stalls", sc[2], 16'd1);
    chk("lat3_flushes",         fc[2], 16'd1);
    clear_counters();

    // dmem freeze for 2 cycles inside a stall
    load_use();
    dmem_busy = 1; step(); step(); dmem_busy = 0;
    repeat (4) step();
    chk("lat2_freeze_stalls", sc[1], 16'd4);
    clear_counters();

    // no stall for x0 destination or unused rs2
    idex_mem_read = 1; idex_rd = 0; ifid_rs1 = 0; ifid_use_rs1 = 1; step();
    idex_rd = 7; ifid_rs1 = 3; ifid_rs2 = 7; ifid_use_rs2 = 0; step();
    idle();
    imem_busy = 1; step(); imem_busy = 0;
    step();

    // clear together with an increment
    load_use();
    cnt_clear = 1; step(); cnt_clear = 0;
    repeat (3) step();
    idle();

    // reset in the middle of a long stall
    load_use();
    idex_mem_read = 1; idex_rd = 5;
    step();
    reset = 1; step(); reset = 0;
    idle();
    step();

    repeat (600) begin
      idex_mem_read = ($urandom_range(0, 1) == 1);
      idex_rd       = 5'($urandom_range(0, 3));
      ifid_rs1      = 5'($urandom_range(0, 3));
      ifid_rs2      = 5'($urandom_range(0, 3));
      ifid_use_rs1  = ($urandom_range(0, 3) != 0);
      ifid_use_rs2  = ($urandom_range(0, 1) == 1);
      redirect      = ($urandom_range(0, 9) == 0);
      dmem_busy     = ($urandom_range(0, 6) == 0);
      imem_busy     = ($urandom_range(0, 6) == 0);
      cnt_clear     = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 150) == 0) begin
        reset = 1; step(); reset = 0;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
